list_sum_engine: RTL

//  Parametrised linked-list summation engine: fused FSM controller + datapath.

---
 rtl/list_sum_engine.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/list_sum_engine.sv
// list_sum_engine
//   Walks a singly linked list held in an external word memory and
//   accumulates the node values. A node at address A stores its next
//   pointer at mem[A] and its value at mem[A+1]; the walk ends after the
//   node whose next pointer is 0. A node limit guards against runaway
//   (cyclic) lists, and carries out of the accumulator are flagged and
//   either wrapped or saturated.
//
// Ports
//   clk_i          system clock
//   rst_n          asynchronous active-low reset
//   step_en_i      pacing enable; a new memory request may only start when 1
//   start_i        one-cycle start pulse, accepted in IDLE/DONE
//   head_addr_i    address of the first node, sampled on accepted start
//   mem_req_o      read request, held until mem_rvalid_i
//   mem_addr_o     read address, stable while mem_req_o=1
//   mem_rdata_i    read data, valid with mem_rvalid_i
//   mem_rvalid_i   read completion (ignored while mem_req_o=0)
//   busy_o         walk in progress
//   done_o         walk finished (level)
//   err_o          sticky: list exceeded MAX_NODES
//   ovf_o          sticky: accumulator overflowed
//   sum_out_o      running / final sum
//   node_cnt_o     nodes accumulated
//
// state    | meaning
// ---------+---------------------------------------------------
// IDLE     | waiting for start after reset
// REQ_NEXT | reading next pointer of current node (mem[cur])
// REQ_VAL  | reading value of current node (mem[cur+1])
// DONE     | walk finished, results held until next start

module list_sum_engine #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 16,
  parameter int SUM_W     = 32,
  parameter int MAX_NODES = 64,
  parameter int SAT_MODE  = 0,
  localparam int CNT_W    = $clog2(MAX_NODES + 1)
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              step_en_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] head_addr_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_rvalid_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              ovf_o,
  output logic [SUM_W-1:0]  sum_out_o,
  output logic [CNT_W-1:0]  node_cnt_o
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_REQ_NEXT = 2'd1,
    S_REQ_VAL  = 2'd2,
    S_DONE     = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_NODES);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cur_q, cur_d;
  logic [ADDR_W-1:0]   nxt_q, nxt_d;
  logic [SUM_W-1:0]    sum_q, sum_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                ovf_q, ovf_d;
  // Request already raised and still waiting for rvalid; keeps mem_req up
  // even if step_en drops.
  logic                hold_q, hold_d;

  logic                xfer;
  logic [SUM_W:0]      sum_add;

  assign xfer    = mem_req_o & mem_rvalid_i;
  assign sum_add = {1'b0, sum_q} + (SUM_W+1)'(mem_rdata_i);

  // State and datapath registers
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cur_q   <= '0;
      nxt_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      nxt_q   <= nxt_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
      hold_q  <= hold_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    nxt_d   = nxt_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    ovf_d   = ovf_q;
    hold_d  = mem_req_o & ~mem_rvalid_i;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          cur_d   = head_addr_i;
          sum_d   = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
          ovf_d   = 1'b0;
          state_d = S_REQ_NEXT;
        end
      end
      S_REQ_NEXT: begin
        if (xfer) begin
          nxt_d   = ADDR_W'(mem_rdata_i);
          state_d = S_REQ_VAL;
        end
      end
      S_REQ_VAL: begin
        if (xfer) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (sum_add[SUM_W]) begin
            ovf_d = 1'b1;
            sum_d = (SAT_MODE != 0) ? '1 : sum_add[SUM_W-1:0];
          end else begin
            sum_d = sum_add[SUM_W-1:0];
          end
          if (nxt_q == '0) begin
            state_d = S_DONE;
          end else if (cnt_q + CNT_W'(1) == MAX_CNT) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            cur_d   = nxt_q;
            state_d = S_REQ_NEXT;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs; mem_req is decoded from state so reset removes it at once.
  always_comb begin
    mem_req_o  = 1'b0;
    mem_addr_o = '0;
    busy_o     = 1'b0;
    done_o     = 1'b0;
    unique case (state_q)
      S_REQ_NEXT: begin
        busy_o     = 1'b1;
        mem_addr_o = cur_q;
        mem_req_o  = step_en_i | hold_q;
      end
      S_REQ_VAL: begin
        busy_o     = 1'b1;
        mem_addr_o = cur_q + ADDR_W'(1);
        mem_req_o  = step_en_i | hold_q;
      end
      S_DONE:  done_o = 1'b1;
      default: ;
    endcase
  end

  assign err_o      = err_q;
  assign ovf_o      = ovf_q;
  assign sum_out_o  = sum_q;
  assign node_cnt_o = cnt_q;

endmodule
